// File: rtl/shift_normalizer_pkg.sv
// Shared constants and types for the leading-bit counter / normalizer.
package shift_normalizer_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int STAGES = 5;

  localparam logic [1:0] OP_CLZ = 2'b00;
  localparam logic [1:0] OP_CLO = 2'b01;
  localparam logic [1:0] OP_CLS = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] norm;
    logic              zero;
  } result_t;

  // Search widths halve each step: 16, 8, 4, 2, 1.
  function automatic logic [CNT_W-1:0] step_width(input logic [2:0] idx);
    return CNT_W'(DATA_W / 2) >> idx;
  endfunction
endpackage

// File: rtl/shift_norm_step.sv
// One binary-search step: test the top width bits against the target and shift on a hit.
module shift_norm_step
  import shift_normalizer_pkg::*;
(
  input  logic [DATA_W-1:0] work_i,
  input  logic              tgt_i,
  input  logic [CNT_W-1:0]  width_i,
  output logic [DATA_W-1:0] shifted_o,
  output logic              hit_o
);
  always_comb begin
    hit_o = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(width_i) && work_i[DATA_W-1-i] != tgt_i) hit_o = 1'b0;
    end
    shifted_o = hit_o ? (work_i << width_i) : work_i;
  end
endmodule

// File: rtl/shift_normalizer.sv
// Iterative CLZ/CLO/CLS with normalization: five binary-search steps, valid/ready handshake.
module shift_normalizer
  import shift_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [1:0]        op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] norm,
  output logic              zero
);
  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [DATA_W-1:0] work_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tgt_q, cls_q;
  result_t           res_q, res_d;

  logic [DATA_W-1:0] step_shift;
  logic              step_hit;
  logic [CNT_W-1:0]  width;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              all_eq;
  logic              accept, last_step;

  assign accept    = in_valid & in_ready & ~flush;
  assign last_step = (state_q == ST_RUN) && (step_q == 3'(STAGES - 1));
  assign width     = step_width(step_q);

  shift_norm_step u_step (
    .work_i    (work_q),
    .tgt_i     (tgt_q),
    .width_i   (width),
    .shifted_o (step_shift),
    .hit_o     (step_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_RUN;
        step_d  = '0;
      end
      ST_RUN: begin
        step_d = step_q + 3'd1;
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Work word and running count; only meaningful between accept and DONE.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_q <= A;
      cnt_q  <= '0;
      tgt_q  <= op[1] ? A[DATA_W-1] : op[0];
      cls_q  <= op[1];
    end else if (state_q == ST_RUN) begin
      work_q <= step_shift;
      cnt_q  <= cnt_nxt;
    end
  end

  assign cnt_nxt = cnt_q + (step_hit ? width : '0);
  assign all_eq  = (step_shift[DATA_W-1] == tgt_q);

  // CLS counts the sign bit itself in the search, so the result is one less
  // and the bit shifted out last (equal to the sign) is put back on top.
  always_comb begin
    res_d = '0;
    if (cls_q) begin
      if (all_eq) begin
        res_d.count = CNT_W'(DATA_W - 1);
        res_d.norm  = {tgt_q, {(DATA_W-1){1'b0}}};
        res_d.zero  = 1'b1;
      end else begin
        res_d.count = cnt_nxt - CNT_W'(1);
        res_d.norm  = {tgt_q, step_shift[DATA_W-1:1]};
      end
    end else if (all_eq) begin
      res_d.count = CNT_W'(DATA_W);
      res_d.zero  = 1'b1;
    end else begin
      res_d.count = cnt_nxt;
      res_d.norm  = step_shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
    end else if (last_step && !flush) begin
      res_q <= res_d;
    end
  end

  assign count = res_q.count;
  assign norm  = res_q.norm;
  assign zero  = res_q.zero;
endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: hand-computed CLZ/CLO/CLS results, handshake, flush, reset.
module tb_shift_normalizer;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [1:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  count;
  logic [31:0] norm;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  shift_normalizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .op        (op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .norm      (norm),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [5:0] ec, input logic [31:0] en, input logic ez);
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".norm"},  norm, en);
    chk({tag, ".zero"},  32'(zero), 32'(ez));
  endtask

  task automatic start_op(input logic [31:0] a, input logic [1:0] o);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    A = a;
    op = o;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done();
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_valid_in_run", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("valid_after_5", 32'(out_valid), 32'd1);
    chk("busy_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drops", 32'(out_valid), 32'd0);
    chk("ready_after_take", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; A = '0; op = 2'b00; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk_res("rst", 6'd0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Basic operations
    start_op(32'h0001_0000, 2'b00); wait_done();
    chk_res("clz_10000", 6'd15, 32'h8000_0000, 1'b0);
    take();
    chk_res("idle_hold", 6'd15, 32'h8000_0000, 1'b0);

    start_op(32'h0000_0000, 2'b00); wait_done();
    chk_res("clz_zero", 6'd32, 32'h0, 1'b1); take();
    start_op(32'hFFFF_FFFF, 2'b01); wait_done();
    chk_res("clo_ones", 6'd32, 32'h0, 1'b1); take();
    start_op(32'hF123_4567, 2'b01); wait_done();
    chk_res("clo_f123", 6'd4, 32'h1234_5670, 1'b0); take();
    start_op(32'hFFFF_8000, 2'b10); wait_done();
    chk_res("cls_ffff8000", 6'd16, 32'h8000_0000, 1'b0); take();
    start_op(32'h0000_0000, 2'b10); wait_done();
    chk_res("cls_zero", 6'd31, 32'h0, 1'b1); take();
    start_op(32'hFFFF_FFFF, 2'b10); wait_done();
    chk_res("cls_ones", 6'd31, 32'h8000_0000, 1'b1); take();
    start_op(32'h0000_0001, 2'b10); wait_done();
    chk_res("cls_one", 6'd30, 32'h4000_0000, 1'b0); take();
    start_op(32'h7FFF_FFFF, 2'b11); wait_done();
    chk_res("cls_7fff", 6'd0, 32'h7FFF_FFFF, 1'b0); take();

    // Backpressure in DONE with a competing request
    start_op(32'h0000_0F00, 2'b00); wait_done();
    repeat (3) begin
      A = 32'h1234_5678; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
      chk_res("bp_hold", 6'd20, 32'hF000_0000, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk_res("bp_4th", 6'd20, 32'hF000_0000, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accept", 32'(in_ready), 32'd0);
    wait_done();
    chk_res("clz_12345678", 6'd3, 32'h91A2_B3C0, 1'b0); take();

    // Flush mid-RUN and flush against a request in IDLE
    start_op(32'h0000_0001, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", 32'(in_ready), 32'd1);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("flush_stays_idle", 32'(out_valid), 32'd0);
    end
    chk_res("flush_keeps_result", 6'd3, 32'h91A2_B3C0, 1'b0);
    A = 32'h0000_0000; op = 2'b00; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 32'(in_ready), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("flush_no_run", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-RUN
    start_op(32'hF123_4567, 2'b01);
    @(posedge clk); #1;
    #3;
    reset = 1'b0;
    #1;
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk_res("arst", 6'd0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    start_op(32'hFFFF_8000, 2'b10); wait_done();
    chk_res("post_rst_cls", 6'd16, 32'h8000_0000, 1'b0); take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
